// File: rtl/instruction_fetch_queue.sv
// Fetch front end: owns the fetch PC, fetches FETCH_WIDTH words per cycle into a circular
// {pc,instr} queue and presents the oldest FETCH_WIDTH entries to the issue controller.
module instruction_fetch_queue #(
   parameter int          FETCH_WIDTH     = 2,
   parameter int          DEPTH           = 8,
   parameter logic [31:0] START_BYTE_ADDR = 32'h0000_3000
) (
   input  logic                             clk,
   input  logic                             rst,
   output logic [31:0]                      imem_addr,
   input  logic [FETCH_WIDTH*32-1:0]        imem_data,
   input  logic                             redirect_valid,
   input  logic [31:0]                      redirect_pc,
   input  logic [$clog2(FETCH_WIDTH+1)-1:0] deq_count,
   output logic [FETCH_WIDTH-1:0]           out_valid,
   output logic [FETCH_WIDTH*32-1:0]        out_pc,
   output logic [FETCH_WIDTH*32-1:0]        out_instr,
   output logic [$clog2(DEPTH+1)-1:0]       occupancy
);

   localparam int PW = $clog2(DEPTH);
   localparam int OW = $clog2(DEPTH+1);

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [OW-1:0] occ_q, occ_d;
   logic [31:0]   pc_mem_q    [DEPTH];
   logic [31:0]   pc_mem_d    [DEPTH];
   logic [31:0]   instr_mem_q [DEPTH];
   logic [31:0]   instr_mem_d [DEPTH];
   logic [OW-1:0] deq_ext;
   logic [OW-1:0] eff_deq;
   logic          enq;

   // Handshake: out_valid[k] offers lane k; deq_count is how many of the oldest valid lanes the
   // consumer takes this cycle (clamped to occupancy). A redirect in the same cycle voids the take.
   always_comb begin
      deq_ext     = OW'(deq_count);
      eff_deq     = (deq_ext > occ_q) ? occ_q : deq_ext;
      enq         = (OW'(DEPTH) - occ_q) >= OW'(FETCH_WIDTH);
      fetch_pc_d  = fetch_pc_q;
      head_d      = head_q;
      tail_d      = tail_q;
      occ_d       = occ_q;
      pc_mem_d    = pc_mem_q;
      instr_mem_d = instr_mem_q;
      if (redirect_valid) begin
         fetch_pc_d = redirect_pc & ~32'h3;
         head_d     = '0;
         tail_d     = '0;
         occ_d      = '0;
      end else begin
         head_d = head_q + PW'(eff_deq);
         occ_d  = occ_q - eff_deq;
         // Room is judged on the pre-dequeue occupancy, so a full queue skips one fetch slot.
         if (enq) begin
            for (int k = 0; k < FETCH_WIDTH; k++) begin
               pc_mem_d[tail_q + PW'(k)]    = fetch_pc_q + 32'(4*k);
               instr_mem_d[tail_q + PW'(k)] = imem_data[k*32 +: 32];
            end
            tail_d     = tail_q + PW'(FETCH_WIDTH);
            occ_d      = occ_d + OW'(FETCH_WIDTH);
            fetch_pc_d = fetch_pc_q + 32'(4*FETCH_WIDTH);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_q <= START_BYTE_ADDR & ~32'h3;
         head_q     <= '0;
         tail_q     <= '0;
         occ_q      <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         occ_q      <= occ_d;
      end
   end

   // Storage contents are don't-care until written; invalid lanes are masked to zero below.
   always_ff @(posedge clk) begin
      pc_mem_q    <= pc_mem_d;
      instr_mem_q <= instr_mem_d;
   end

   always_comb begin
      imem_addr = fetch_pc_q;
      occupancy = occ_q;
      out_valid = '0;
      out_pc    = '0;
      out_instr = '0;
      for (int k = 0; k < FETCH_WIDTH; k++) begin
         if (OW'(k) < occ_q) begin
            out_valid[k]         = 1'b1;
            out_pc[k*32 +: 32]    = pc_mem_q[head_q + PW'(k)];
            out_instr[k*32 +: 32] = instr_mem_q[head_q + PW'(k)];
         end
      end
   end

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Bench for instruction_fetch_queue: hand-derived vector table, a steady-stream sequence and
// randomized traffic checked against a queue-based reference model.
module tb_instruction_fetch_queue;

   localparam int          FW    = 2;
   localparam int          DEPTH = 8;
   localparam logic [31:0] START = 32'h0000_3000;

   logic              clk;
   logic              rst;
   logic [31:0]       imem_addr;
   logic [FW*32-1:0]  imem_data;
   logic              redirect_valid;
   logic [31:0]       redirect_pc;
   logic [1:0]        deq_count;
   logic [FW-1:0]     out_valid;
   logic [FW*32-1:0]  out_pc;
   logic [FW*32-1:0]  out_instr;
   logic [3:0]        occupancy;

   int checks   = 0;
   int failures = 0;

   instruction_fetch_queue #(
      .FETCH_WIDTH(FW), .DEPTH(DEPTH), .START_BYTE_ADDR(START)
   ) dut (
      .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .deq_count(deq_count),
      .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr), .occupancy(occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
   endfunction

   // Instruction memory: word at any address is a fixed hash of that address.
   always_comb begin
      imem_data = '0;
      for (int k = 0; k < FW; k++) imem_data[k*32 +: 32] = instr_of(imem_addr + 32'(4*k));
   end

   // Reference model: a plain FIFO of fetched {pc,instr} pairs plus the fetch PC.
   logic [31:0] m_pc[$];
   logic [31:0] m_in[$];
   logic [31:0] m_fetch;

   task automatic model_step(input logic r, input logic rv, input logic [31:0] rpc,
                             input int deq);
      int occ;
      int eff;
      if (r) begin
         m_fetch = START;
         m_pc.delete();
         m_in.delete();
      end else if (rv) begin
         m_fetch = {rpc[31:2], 2'b00};
         m_pc.delete();
         m_in.delete();
      end else begin
         occ = m_pc.size();
         eff = (deq < occ) ? deq : occ;
         for (int i = 0; i < eff; i++) begin
            void'(m_pc.pop_front());
            void'(m_in.pop_front());
         end
         if (DEPTH - occ >= FW) begin
            for (int k = 0; k < FW; k++) begin
               m_pc.push_back(m_fetch + 32'(4*k));
               m_in.push_back(instr_of(m_fetch + 32'(4*k)));
            end
            m_fetch = m_fetch + 32'(4*FW);
         end
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_model(input string tag);
      logic        v;
      logic [31:0] p;
      logic [31:0] n;
      chk({tag, "_occ"}, 32'(occupancy), 32'(m_pc.size()));
      chk({tag, "_addr"}, imem_addr, m_fetch);
      for (int k = 0; k < FW; k++) begin
         v = (k < m_pc.size());
         p = v ? m_pc[k] : 32'h0;
         n = v ? m_in[k] : 32'h0;
         chk($sformatf("%s_valid%0d", tag, k), 32'(out_valid[k]), 32'(v));
         chk($sformatf("%s_pc%0d", tag, k), out_pc[k*32 +: 32], p);
         chk($sformatf("%s_instr%0d", tag, k), out_instr[k*32 +: 32], n);
      end
   endtask

   // Drive inputs (called at a falling edge), take one rising edge, return at the next falling edge.
   task automatic apply(input logic r, input logic rv, input logic [31:0] rpc, input logic [1:0] dq);
      rst            = r;
      redirect_valid = rv;
      redirect_pc    = rpc;
      deq_count      = dq;
      @(posedge clk);
      model_step(r, rv, rpc, int'(dq));
      @(negedge clk);
   endtask

   typedef struct packed {
      logic        rst;
      logic        redir;
      logic [31:0] rpc;
      logic [1:0]  deq;
      logic [3:0]  occ;
      logic [31:0] addr;
      logic [1:0]  valid;
      logic [31:0] pc0;
      logic [31:0] pc1;
   } vec_t;

   localparam int NV = 22;
   vec_t tbl[NV];

   initial begin
      logic [31:0] prev_pc;
      logic        r_rst;
      logic        r_rv;

      // Expected state after each row's clock edge.
      tbl[0]  = '{1'b1, 1'b0, 32'h0, 2'd0, 4'd0, 32'h3000, 2'b00, 32'h0, 32'h0};
      tbl[1]  = '{1'b1, 1'b0, 32'h0, 2'd0, 4'd0, 32'h3000, 2'b00, 32'h0, 32'h0};
      tbl[2]  = '{1'b0, 1'b0, 32'h0, 2'd0, 4'd2, 32'h3008, 2'b11, 32'h3000, 32'h3004};
      tbl[3]  = '{1'b0, 1'b0, 32'h0, 2'd0, 4'd4, 32'h3010, 2'b11, 32'h3000, 32'h3004};
      tbl[4]  = '{1'b0, 1'b0, 32'h0, 2'd0, 4'd6, 32'h3018, 2'b11, 32'h3000, 32'h3004};
      tbl[5]  = '{1'b0, 1'b0, 32'h0, 2'd0, 4'd8, 32'h3020, 2'b11, 32'h3000, 32'h3004};
      tbl[6]  = '{1'b0, 1'b0, 32'h0, 2'd0, 4'd8, 32'h3020, 2'b11, 32'h3000, 32'h3004};
      tbl[7]  = '{1'b0, 1'b0, 32'h0, 2'd0, 4'd8, 32'h3020, 2'b11, 32'h3000, 32'h3004};
      tbl[8]  = '{1'b0, 1'b0, 32'h0, 2'd2, 4'd6, 32'h3020, 2'b11, 32'h3008, 32'h300C};
      tbl[9]  = '{1'b0, 1'b0, 32'h0, 2'd0, 4'd8, 32'h3028, 2'b11, 32'h3008, 32'h300C};
      tbl[10] = '{1'b0, 1'b0, 32'h0, 2'd1, 4'd7, 32'h3028, 2'b11, 32'h300C, 32'h3010};
      tbl[11] = '{1'b0, 1'b0, 32'h0, 2'd1, 4'd6, 32'h3028, 2'b11, 32'h3010, 32'h3014};
      tbl[12] = '{1'b0, 1'b1, 32'h3043, 2'd2, 4'd0, 32'h3040, 2'b00, 32'h0, 32'h0};
      tbl[13] = '{1'b0, 1'b0, 32'h0, 2'd0, 4'd2, 32'h3048, 2'b11, 32'h3040, 32'h3044};
      tbl[14] = '{1'b0, 1'b0, 32'h0, 2'd1, 4'd3, 32'h3050, 2'b11, 32'h3044, 32'h3048};
      tbl[15] = '{1'b0, 1'b1, 32'hFFFF_FFF9, 2'd0, 4'd0, 32'hFFFF_FFF8, 2'b00, 32'h0, 32'h0};
      tbl[16] = '{1'b0, 1'b0, 32'h0, 2'd2, 4'd2, 32'h0000_0000, 2'b11, 32'hFFFF_FFF8, 32'hFFFF_FFFC};
      tbl[17] = '{1'b0, 1'b0, 32'h0, 2'd1, 4'd3, 32'h0000_0008, 2'b11, 32'hFFFF_FFFC, 32'h0};
      tbl[18] = '{1'b0, 1'b0, 32'h0, 2'd2, 4'd3, 32'h0000_0010, 2'b11, 32'h4, 32'h8};
      tbl[19] = '{1'b0, 1'b0, 32'h0, 2'd3, 4'd2, 32'h0000_0018, 2'b11, 32'h10, 32'h14};
      tbl[20] = '{1'b1, 1'b1, 32'h5555, 2'd2, 4'd0, 32'h3000, 2'b00, 32'h0, 32'h0};
      tbl[21] = '{1'b0, 1'b0, 32'h0, 2'd0, 4'd2, 32'h3008, 2'b11, 32'h3000, 32'h3004};

      rst            = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      deq_count      = '0;
      m_fetch        = START;

      for (int i = 0; i < NV; i++) begin
         apply(tbl[i].rst, tbl[i].redir, tbl[i].rpc, tbl[i].deq);
         chk($sformatf("vec%0d_occ", i), 32'(occupancy), 32'(tbl[i].occ));
         chk($sformatf("vec%0d_addr", i), imem_addr, tbl[i].addr);
         chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(tbl[i].valid));
         chk($sformatf("vec%0d_pc0", i), out_pc[31:0], tbl[i].pc0);
         chk($sformatf("vec%0d_pc1", i), out_pc[63:32], tbl[i].pc1);
         chk($sformatf("vec%0d_instr0", i), out_instr[31:0],
             tbl[i].valid[0] ? instr_of(tbl[i].pc0) : 32'h0);
         chk($sformatf("vec%0d_instr1", i), out_instr[63:32],
             tbl[i].valid[1] ? instr_of(tbl[i].pc1) : 32'h0);
         check_model($sformatf("vecm%0d", i));
      end

      // Steady two-per-cycle consumption: occupancy pinned at 2, head PC advancing by 8 through
      // several pointer wraps.
      prev_pc = out_pc[31:0];
      for (int i = 0; i < 20; i++) begin
         apply(1'b0, 1'b0, 32'h0, 2'd2);
         chk("steady_occ", 32'(occupancy), 32'd2);
         chk("steady_pc_step", out_pc[31:0], prev_pc + 32'd8);
         check_model("steady");
         prev_pc = out_pc[31:0];
      end

      // Randomized traffic against the reference model.
      for (int i = 0; i < 600; i++) begin
         r_rst = ($urandom_range(0, 99) < 2);
         r_rv  = ($urandom_range(0, 99) < 6);
         apply(r_rst, r_rv, $urandom, 2'($urandom_range(0, 3)));
         check_model("rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
